// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// nibble_serial_addsub_ctrl_pkg: shared FSM state encodings and nibble width
package nibble_serial_addsub_ctrl_pkg;
    localparam int NIBBLE_W = 4;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/nibble_serial_addsub_ctrl_rca.sv
// four_bit_rca: 4-bit ripple-carry adder shared across all nibbles
module four_bit_rca
    import nibble_serial_addsub_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);
    logic [NIBBLE_W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: W-bit add/subtract sequenced LSB-first over one shared 4-bit adder
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, result_q, result_d;
    logic                sub_q, sub_d, carry_q, carry_d;
    logic                cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
    logic                rca_co;

    // B is inverted for subtraction; the initial carry of 1 completes the two's complement
    assign a_nib = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx_q * NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

    four_bit_rca u_rca (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (sum_nib),
        .cout (rca_co)
    );

    // Next-state: accept in IDLE, one nibble per RUN cycle, flags settle on the last nibble
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                idx_d    = '0;
                a_d      = a;
                b_d      = b;
                sub_d    = subtract;
                carry_d  = subtract;
                result_d = '0;
                cout_d   = 1'b0;
                ovf_d    = 1'b0;
                zero_d   = 1'b0;
            end
            RUN: begin
                result_d[idx_q * NIBBLE_W +: NIBBLE_W] = sum_nib;
                carry_d = rca_co;
                idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = rca_co;
                    ovf_d   = (a_nib[NIBBLE_W-1] == b_nib[NIBBLE_W-1]) &&
                              (sum_nib[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
                    zero_d  = ~|result_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb_nibble_serial_addsub_ctrl: directed checks of the nibble-serial add/subtract controller
module tb_nibble_serial_addsub_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        subtract = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, overflow, zero;
    logic [15:0] result;
    int          n_checks = 0;
    int          n_pass = 0;

    nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .subtract (subtract),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: {zero, overflow, cout, result} from plain wide arithmetic
    function automatic logic [18:0] model(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        logic [15:0] be;
        logic [16:0] full;
        logic        ov;
        be   = sv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, be} + {16'b0, sv};
        ov   = (av[15] == be[15]) && (full[15] != av[15]);
        return {full[15:0] == 16'h0, ov, full[16], full[15:0]};
    endfunction

    // One operation from an IDLE negedge; inputs are scrambled while running to test isolation
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic [15:0] er, input logic ec, input logic eo, input logic ez);
        int lat = 0;
        int bc = 0;
        @(negedge clk);
        a = av; b = bv; subtract = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            if (busy) bc++;
            a = ~a; b = b + 16'h1357; subtract = ~subtract;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_busycyc"}, bc, 4);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_result"}, {16'b0, result}, {16'b0, er});
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
        chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, eo});
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_hold"}, {16'b0, result}, {16'b0, er});
    endtask

    initial begin
        logic [18:0] exp_v;
        logic [15:0] ha, hb, acc_a, acc_b;
        logic        hs, acc_s;
        exp_v = '0;
        acc_a = '0; acc_b = '0; acc_s = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_flags", {29'b0, cout, overflow, zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_op("add",      16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_brw",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_nb",   16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_zero", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        // start held high with operands changing every cycle: accepts only every 6 cycles
        for (int k = 0; k < 18; k++) begin
            ha = 16'(k * 16'h1357 + 16'h0F0F);
            hb = 16'(k * 16'h2468 + 16'h00F1);
            hs = k[1];
            if (k % 6 == 0) begin
                if (k > 0) begin
                    chk("hs_idle_busy", {31'b0, busy}, 32'd0);
                    chk("hs_idle_done", {31'b0, done}, 32'd0);
                    chk("hs_hold", {13'b0, zero, overflow, cout, result}, {13'b0, exp_v});
                end
                acc_a = ha; acc_b = hb; acc_s = hs;
            end else if (k % 6 == 5) begin
                exp_v = model(acc_a, acc_b, acc_s);
                chk("hs_done", {31'b0, done}, 32'd1);
                chk("hs_out", {13'b0, zero, overflow, cout, result}, {13'b0, exp_v});
            end else begin
                chk("hs_busy", {31'b0, busy}, 32'd1);
            end
            a = ha; b = hb; subtract = hs; start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk("hs_end_hold", {13'b0, zero, overflow, cout, result}, {13'b0, exp_v});
        @(negedge clk);
        // reset asserted during the second RUN cycle
        a = 16'h1234; b = 16'h1111; subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_result", {16'b0, result}, 32'd0);
        chk("mid_rst_flags", {29'b0, cout, overflow, zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {30'b0, busy, done}, 32'd0);
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
